// File: rtl/router_pkg.sv
// Shared encodings and helpers for the router output scheduler.
package router_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StHeader  = 2'b01,
    StPayload = 2'b10,
    StParity  = 2'b11
  } state_e;

  // Header byte layout: {len, addr[1:0]}
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned LEN_LSB  = ADDR_LSB + 2;

  localparam logic [1:0] GRANT_NONE = 2'd3;

  function automatic logic [1:0] mod3_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter_3.sv
// Three-way round-robin pick: first requester after last, wrapping back to last itself.
module rr_arbiter_3
  import router_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] next_grant_o,
  output logic       any_req_o
);

  logic [1:0] cand1;
  logic [1:0] cand2;

  // Lowest priority assigned first so later, higher-priority hits override it.
  always_comb begin
    cand1        = mod3_inc(last_i);
    cand2        = mod3_inc(cand1);
    any_req_o    = |req_i;
    next_grant_o = last_i;
    if (req_i[cand2]) next_grant_o = cand2;
    if (req_i[cand1]) next_grant_o = cand1;
  end

endmodule

// File: rtl/router_out_scheduler.sv
// Packet-granular round-robin scheduler draining three FWFT output FIFOs onto one link,
// with a per-packet stall watchdog that aborts and soft-resets a stuck FIFO.
module router_out_scheduler
  import router_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LEN_W   = 6,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_dout_0_i,
  input  logic [DATA_W-1:0] fifo_dout_1_i,
  input  logic [DATA_W-1:0] fifo_dout_2_i,
  input  logic              link_ready_i,
  output logic [2:0]        fifo_rd_en_o,
  output logic [DATA_W-1:0] link_data_o,
  output logic              link_valid_o,
  output logic              link_sop_o,
  output logic              link_eop_o,
  output logic [1:0]        grant_o,
  output logic              soft_reset_0_o,
  output logic              soft_reset_1_o,
  output logic              soft_reset_2_o
);

  localparam int unsigned WdogW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT - 1);

  state_e           state_q;
  logic [1:0]       grant_q;
  logic [1:0]       last_q;
  logic [LEN_W-1:0] cnt_q;
  logic [WdogW-1:0] wdog_q;
  logic [2:0]       soft_reset_q;

  logic [2:0]       grant_oh;
  logic             head_empty;
  logic             hs;
  logic             abort;
  logic             any_req;
  logic [1:0]       next_grant;
  logic [LEN_W-1:0] hdr_len;

  rr_arbiter_3 u_arb (
    .req_i        (~fifo_empty_i),
    .last_i       (last_q),
    .next_grant_o (next_grant),
    .any_req_o    (any_req)
  );

  always_comb begin
    link_data_o = '0;
    head_empty  = 1'b1;
    grant_oh    = 3'b000;
    case (grant_q)
      2'd0: begin
        link_data_o = fifo_dout_0_i;
        head_empty  = fifo_empty_i[0];
        grant_oh    = 3'b001;
      end
      2'd1: begin
        link_data_o = fifo_dout_1_i;
        head_empty  = fifo_empty_i[1];
        grant_oh    = 3'b010;
      end
      2'd2: begin
        link_data_o = fifo_dout_2_i;
        head_empty  = fifo_empty_i[2];
        grant_oh    = 3'b100;
      end
      default: ;
    endcase
  end

  assign link_valid_o = (state_q != StIdle) && !head_empty;
  assign hs           = link_valid_o && link_ready_i;
  assign link_sop_o   = link_valid_o && (state_q == StHeader);
  assign link_eop_o   = link_valid_o && (state_q == StParity);
  assign fifo_rd_en_o = hs ? grant_oh : 3'b000;
  assign hdr_len      = link_data_o[LEN_LSB +: LEN_W];
  // A handshake in the timeout cycle takes precedence over the abort.
  assign abort        = (state_q != StIdle) && !hs && (wdog_q == WdogMax);

  assign grant_o        = grant_q;
  assign soft_reset_0_o = soft_reset_q[0];
  assign soft_reset_1_o = soft_reset_q[1];
  assign soft_reset_2_o = soft_reset_q[2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      grant_q      <= GRANT_NONE;
      last_q       <= 2'd2;
      cnt_q        <= '0;
      wdog_q       <= '0;
      soft_reset_q <= 3'b000;
    end else begin
      soft_reset_q <= 3'b000;
      if (state_q != StIdle) wdog_q <= hs ? '0 : wdog_q + 1'b1;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q <= next_grant;
            last_q  <= next_grant;
            wdog_q  <= '0;
            state_q <= StHeader;
          end
        end
        StHeader: begin
          if (hs) begin
            cnt_q   <= hdr_len;
            state_q <= (hdr_len == '0) ? StParity : StPayload;
          end
        end
        StPayload: begin
          if (hs) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == LEN_W'(1)) state_q <= StParity;
          end
        end
        StParity: begin
          if (hs) begin
            state_q <= StIdle;
            grant_q <= GRANT_NONE;
          end
        end
        default: state_q <= StIdle;
      endcase
      // last_q keeps the aborted port so it goes to the back of the rotation.
      if (abort) begin
        state_q      <= StIdle;
        grant_q      <= GRANT_NONE;
        wdog_q       <= '0;
        soft_reset_q <= grant_oh;
      end
    end
  end

endmodule

// File: tb/tb_router_out_scheduler.sv
// Directed bench for router_out_scheduler with three behavioural FWFT FIFOs.
module tb_router_out_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] fifo_empty;
  logic [7:0] dout0, dout1, dout2;
  logic       link_ready = 1'b1;
  logic [2:0] rd_en;
  logic [7:0] link_data;
  logic       link_valid, sop, eop;
  logic [1:0] grant;
  logic [2:0] sr;

  logic [7:0] mem [3][256];
  int         head [3];
  int         tail [3];
  logic       fifo_clr = 1'b0;

  int checks = 0;
  int passed = 0;

  logic [7:0] cap_data [$];
  logic       cap_sop  [$];
  logic       cap_eop  [$];
  logic [1:0] cap_port [$];
  logic [2:0] cap_rd   [$];
  int         cap_cyc  [$];

  always #5 clk = ~clk;

  assign fifo_empty[0] = (head[0] == tail[0]);
  assign fifo_empty[1] = (head[1] == tail[1]);
  assign fifo_empty[2] = (head[2] == tail[2]);
  assign dout0 = mem[0][head[0][7:0]];
  assign dout1 = mem[1][head[1][7:0]];
  assign dout2 = mem[2][head[2][7:0]];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (fifo_clr || sr[k]) head[k] <= tail[k];
      else if (rd_en[k]) head[k] <= head[k] + 1;
    end
  end

  router_out_scheduler #(.DATA_W(8), .LEN_W(6), .TIMEOUT(30)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty_i   (fifo_empty),
    .fifo_dout_0_i  (dout0),
    .fifo_dout_1_i  (dout1),
    .fifo_dout_2_i  (dout2),
    .link_ready_i   (link_ready),
    .fifo_rd_en_o   (rd_en),
    .link_data_o    (link_data),
    .link_valid_o   (link_valid),
    .link_sop_o     (sop),
    .link_eop_o     (eop),
    .grant_o        (grant),
    .soft_reset_0_o (sr[0]),
    .soft_reset_1_o (sr[1]),
    .soft_reset_2_o (sr[2])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input logic [7:0] b);
    mem[p][tail[p][7:0]] = b;
    tail[p] = tail[p] + 1;
  endtask

  // Records every handshake over a fixed window; checking is done by the caller.
  task automatic capture(input int cycles);
    cap_data.delete(); cap_sop.delete(); cap_eop.delete();
    cap_port.delete(); cap_rd.delete(); cap_cyc.delete();
    for (int c = 0; c < cycles; c++) begin
      if (link_valid && link_ready) begin
        cap_data.push_back(link_data);
        cap_sop.push_back(sop);
        cap_eop.push_back(eop);
        cap_port.push_back(grant);
        cap_rd.push_back(rd_en);
        cap_cyc.push_back(c);
      end
      step();
    end
  endtask

  task automatic test_reset();
    checks++; if (grant !== 2'd3) $display("FAIL reset_grant: got %0d want 3", grant);
    else passed++;
    checks++; if (link_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", link_valid);
    else passed++;
    checks++; if (rd_en !== 3'b000) $display("FAIL reset_rd_en: got %b want 000", rd_en);
    else passed++;
    checks++; if ({sop, eop} !== 2'b00) $display("FAIL reset_sop_eop: got %b want 00", {sop, eop});
    else passed++;
    checks++; if (sr !== 3'b000) $display("FAIL reset_soft: got %b want 000", sr);
    else passed++;
    checks++; if (link_data !== 8'h00) $display("FAIL reset_data: got %h want 00", link_data);
    else passed++;
    push(1, 8'h0D);
    step();
    checks++; if (grant !== 2'd3) $display("FAIL reset_hold_grant: got %0d want 3", grant);
    else passed++;
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [7:0] exp [5] = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5C};
    push(1, 8'h0D); push(1, 8'hA1); push(1, 8'hA2); push(1, 8'hA3); push(1, 8'h5C);
    capture(10);
    checks++;
    if (cap_data.size() != 5) $display("FAIL single_count: got %0d want 5", cap_data.size());
    else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= cap_data.size()) $display("FAIL single_byte%0d: missing want %h", i, exp[i]);
      else if (cap_data[i] !== exp[i] || cap_sop[i] !== (i == 0) || cap_eop[i] !== (i == 4) ||
               cap_port[i] !== 2'd1 || cap_rd[i] !== 3'b010)
        $display("FAIL single_byte%0d: got %h sop%b eop%b g%0d rd%b want %h sop%b eop%b g1 rd010",
                 i, cap_data[i], cap_sop[i], cap_eop[i], cap_port[i], cap_rd[i], exp[i],
                 i == 0, i == 4);
      else passed++;
    end
    checks++;
    if (cap_cyc.size() != 5 || cap_cyc[4] - cap_cyc[0] != 4)
      $display("FAIL single_contig: got %0d bytes, span not 4", cap_cyc.size());
    else passed++;
    checks++; if (grant !== 2'd3) $display("FAIL single_end_grant: got %0d want 3", grant);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [7:0] e1 [9] = '{8'h04, 8'hC0, 8'h50, 8'h05, 8'hC1, 8'h51, 8'h06, 8'hC2, 8'h52};
    int         p1 [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    logic [7:0] e2 [9] = '{8'h04, 8'hD0, 8'h60, 8'h05, 8'hD1, 8'h61, 8'h04, 8'hE0, 8'h70};
    int         p2 [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    reset = 1'b0; fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    push(0, 8'h04); push(0, 8'hC0); push(0, 8'h50);
    push(1, 8'h05); push(1, 8'hC1); push(1, 8'h51);
    push(2, 8'h06); push(2, 8'hC2); push(2, 8'h52);
    step();
    reset = 1'b1;
    capture(16);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= cap_data.size()) $display("FAIL rr1_byte%0d: missing want %h", i, e1[i]);
      else if (cap_data[i] !== e1[i] || int'(cap_port[i]) != p1[i])
        $display("FAIL rr1_byte%0d: got %h g%0d want %h g%0d", i, cap_data[i], cap_port[i],
                 e1[i], p1[i]);
      else passed++;
    end
    // Port 0 has two packets queued but must yield to port 1 in between.
    push(0, 8'h04); push(0, 8'hD0); push(0, 8'h60);
    push(0, 8'h04); push(0, 8'hE0); push(0, 8'h70);
    push(1, 8'h05); push(1, 8'hD1); push(1, 8'h61);
    capture(16);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= cap_data.size()) $display("FAIL rr2_byte%0d: missing want %h", i, e2[i]);
      else if (cap_data[i] !== e2[i] || int'(cap_port[i]) != p2[i])
        $display("FAIL rr2_byte%0d: got %h g%0d want %h g%0d", i, cap_data[i], cap_port[i],
                 e2[i], p2[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [6] = '{8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};
    logic [7:0] got [$];
    logic       held_v = 1'b0;
    logic [7:0] held_d = 8'h00;
    int         pops = 0;
    int         stalls = 0;
    push(0, 8'h10); push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
    push(0, 8'h5A);
    for (int c = 0; c < 30; c++) begin
      link_ready = (c % 2) == 1;
      #1;
      if (held_v && link_valid) begin
        stalls++;
        checks++;
        if (link_data !== held_d)
          $display("FAIL bp_stable_c%0d: got %h want %h", c, link_data, held_d);
        else passed++;
      end
      held_v = link_valid && !link_ready;
      held_d = link_data;
      if (link_valid && link_ready) got.push_back(link_data);
      pops += $countones(rd_en);
      step();
    end
    link_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got.size()) $display("FAIL bp_byte%0d: missing want %h", i, exp[i]);
      else if (got[i] !== exp[i]) $display("FAIL bp_byte%0d: got %h want %h", i, got[i], exp[i]);
      else passed++;
    end
    checks++; if (pops != 6) $display("FAIL bp_pops: got %0d want 6", pops);
    else passed++;
    checks++; if (stalls == 0) $display("FAIL bp_stalls: got 0 want >0");
    else passed++;
  endtask

  task automatic test_zero_len();
    push(2, 8'h02); push(2, 8'h7E);
    capture(8);
    checks++;
    if (cap_data.size() != 2) $display("FAIL zl_count: got %0d want 2", cap_data.size());
    else passed++;
    checks++;
    if (cap_data.size() < 1 || cap_data[0] !== 8'h02 || cap_sop[0] !== 1'b1 ||
        cap_eop[0] !== 1'b0 || cap_rd[0] !== 3'b100)
      $display("FAIL zl_hdr: got %0d bytes, first not 02 sop rd100", cap_data.size());
    else passed++;
    checks++;
    if (cap_data.size() < 2 || cap_data[1] !== 8'h7E || cap_sop[1] !== 1'b0 ||
        cap_eop[1] !== 1'b1 || cap_cyc[1] - cap_cyc[0] != 1)
      $display("FAIL zl_parity: got %0d bytes, second not 7E eop contiguous", cap_data.size());
    else passed++;
    checks++; if (grant !== 2'd3) $display("FAIL zl_end_grant: got %0d want 3", grant);
    else passed++;
  endtask

  task automatic test_watchdog();
    int last_hs0 = -1, n_hs0 = 0, n_hs1 = 0, pulses = 0, pulse_c = -1, bad = 0;
    logic [1:0] g_pulse = 2'd0, g_after = 2'd0;
    logic       v_pulse = 1'b1;
    push(0, 8'h14); push(0, 8'hB1); push(0, 8'hB2);
    push(1, 8'h01); push(1, 8'h99);
    for (int c = 0; c < 50; c++) begin
      if (link_valid && link_ready && grant == 2'd0) begin n_hs0++; last_hs0 = c; end
      if (link_valid && link_ready && grant == 2'd1) n_hs1++;
      if (sr[0]) begin pulses++; pulse_c = c; g_pulse = grant; v_pulse = link_valid; end
      if (sr[2:1] != 2'b00) bad++;
      if (pulse_c >= 0 && c == pulse_c + 1) g_after = grant;
      step();
    end
    checks++; if (n_hs0 != 3) $display("FAIL wd_port0_bytes: got %0d want 3", n_hs0);
    else passed++;
    checks++; if (pulses != 1) $display("FAIL wd_pulse_count: got %0d want 1", pulses);
    else passed++;
    checks++;
    if (pulse_c - last_hs0 != 31)
      $display("FAIL wd_delay: got %0d want 31 cycles after last hs", pulse_c - last_hs0);
    else passed++;
    checks++;
    if (g_pulse !== 2'd3 || v_pulse !== 1'b0)
      $display("FAIL wd_idle: got grant %0d valid %b want 3 0", g_pulse, v_pulse);
    else passed++;
    checks++; if (g_after !== 2'd1) $display("FAIL wd_next_grant: got %0d want 1", g_after);
    else passed++;
    checks++; if (bad != 0) $display("FAIL wd_other_soft: got %0d want 0", bad);
    else passed++;
    checks++; if (n_hs1 != 2) $display("FAIL wd_port1_bytes: got %0d want 2", n_hs1);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int  n = 0;
    bit  hit = 0;
    push(1, 8'h0D); push(1, 8'hA1); push(1, 8'hA2); push(1, 8'hA3); push(1, 8'h5C);
    for (int c = 0; c < 20 && !hit; c++) begin
      if (link_valid && link_ready) n++;
      if (n == 3) begin
        hit = 1;
        reset = 1'b0;
      end
      step();
    end
    checks++; if (!hit) $display("FAIL rm_reach: got %0d hs want 3", n);
    else passed++;
    checks++; if (grant !== 2'd3) $display("FAIL rm_grant: got %0d want 3", grant);
    else passed++;
    checks++; if (link_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", link_valid);
    else passed++;
    checks++; if (rd_en !== 3'b000) $display("FAIL rm_rd_en: got %b want 000", rd_en);
    else passed++;
    checks++; if (sr !== 3'b000) $display("FAIL rm_soft: got %b want 000", sr);
    else passed++;
    step();
    checks++;
    if (sr !== 3'b000 || grant !== 2'd3)
      $display("FAIL rm_hold: got soft %b grant %0d want 000 3", sr, grant);
    else passed++;
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    reset = 1'b1;
    step();
  endtask

  initial begin
    step();
    step();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_zero_len();
    test_watchdog();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
